uart_tx_frame: RTL and testbench

Transmit-side frame controller and serializer for the UART TX path. It accepts a parallel byte, latches it, and shifts out a complete UART frame on a single serial line, one bit per CLK cycle: start bit, data LSB-first, optional parity, stop bit. It consumes the registered parity bit produced by the parity calculator stage, which is driven by the same DATA_VALID strobe. It reports occupancy through Busy so the upstream data source can pace transfers.

---
 rtl/uart_tx_frame_if.sv | 32 +++
 rtl/uart_tx_frame.sv | 96 +++++++++
 tb/tb_uart_tx_frame.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// UART TX frame handshake bundle: parallel byte, strobe, parity config
// and parity bit toward the serializer; serial line and Busy back out.
//   P_DATA/DATA_VALID/PAR_EN/par_bit : source -> serializer
//   TX_OUT/Busy                      : serializer -> line / source
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  par_bit;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA,
      output DATA_VALID,
      output PAR_EN,
      output par_bit,
      input  TX_OUT,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  DATA_VALID,
      input  PAR_EN,
      input  par_bit,
      output TX_OUT,
      output Busy
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART TX frame controller/serializer: start, LSB-first data,
// optional parity, stop; one bit per CLK.
//   CLK : bit clock
//   RST : async active-low reset
//   bus : uart_tx_frame_if slave (data/strobe/config in, line/Busy out)
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input logic            CLK,
   input logic            RST,
   uart_tx_frame_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] sh;
   logic [CW-1:0]         cnt;
   logic                  par_q;
   logic                  cfg_par;
   logic                  tx;
   logic                  busy;

   assign bus.TX_OUT = tx;
   assign bus.Busy   = busy;

   // Outputs are registered from the next state, so each state's
   // line value appears in the same cycle the state is entered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         sh      <= '0;
         cnt     <= '0;
         par_q   <= 1'b0;
         cfg_par <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            IDLE, STOP: begin
               if (bus.DATA_VALID) begin
                  sh      <= bus.P_DATA;
                  cfg_par <= bus.PAR_EN;
                  cnt     <= '0;
                  state   <= START;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
               end else begin
                  state <= IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            START: begin
               // Only par_bit sample of the frame.
               par_q <= bus.par_bit;
               state <= DATA;
               tx    <= sh[0];
               sh    <= sh >> 1;
            end
            DATA: begin
               if (cnt == LAST) begin
                  if (cfg_par) begin
                     state <= PARITY;
                     tx    <= par_q;
                  end else begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  tx  <= sh[0];
                  sh  <= sh >> 1;
               end
            end
            PARITY: begin
               state <= STOP;
               tx    <= 1'b1;
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus random
// traffic, checked per cycle against a frame-level line model.
module tb_uart_tx_frame;
   localparam int W = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

   uart_tx_frame #(.DATA_WIDTH(W)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   // Expected line/Busy per cycle; absent cycle means idle line.
   bit exp_tx [int];
   bit exp_bz [int];
   int busy_until = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  tag, cyc, got, want);
      end
   endtask

   always @(negedge CLK) begin
      check("tx", {31'd0, bus.TX_OUT},
            {31'd0, exp_tx.exists(cyc) ? exp_tx[cyc] : 1'b1});
      check("busy", {31'd0, bus.Busy},
            {31'd0, exp_bz.exists(cyc) ? exp_bz[cyc] : 1'b0});
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_until(input int t);
      int g = 0;
      while (cyc < t && g < 200) begin
         step();
         g++;
      end
      if (cyc < t) check("wait", cyc, t);
   endtask

   // Strobe in this cycle; parity stage answers next cycle.
   // The line is free from the stop cycle of the current frame on.
   task automatic send(input logic [W-1:0] d,
                       input bit pen,
                       input bit pb);
      int len;
      bit b;
      bus.P_DATA     = d;
      bus.PAR_EN     = pen;
      bus.DATA_VALID = 1'b1;
      if (cyc >= busy_until) begin
         len = pen ? W + 3 : W + 2;
         for (int k = 0; k < len; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= W) b = d[k-1];
            else if (pen && k == W + 1) b = pb;
            else b = 1'b1;
            exp_tx[cyc+1+k] = b;
            exp_bz[cyc+1+k] = 1'b1;
         end
         busy_until = cyc + len;
      end
      step();
      bus.DATA_VALID = 1'b0;
      bus.P_DATA     = W'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.par_bit    = pb;
      step();
      bus.par_bit    = 1'($urandom);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.par_bit    = 1'b0;
      repeat (3) step();
      RST = 1'b1;
      step();

      send(8'hA5, 1'b1, 1'b1);
      wait_until(busy_until + 3);

      send(8'h3C, 1'b0, 1'b0);
      wait_until(busy_until + 3);

      send(8'h01, 1'b1, 1'b0);
      wait_until(busy_until);
      send(8'h80, 1'b0, 1'b1);
      wait_until(busy_until + 3);

      send(8'h00, 1'b1, 1'b0);
      step();
      send(8'hFF, 1'b0, 1'b1);
      wait_until(busy_until + 3);

      send(8'hC3, 1'b1, 1'b1);
      repeat (4) step();
      #1;
      RST = 1'b0;
      exp_tx.delete();
      exp_bz.delete();
      busy_until = 0;
      #1;
      check("rst_tx", {31'd0, bus.TX_OUT}, 32'd1);
      check("rst_busy", {31'd0, bus.Busy}, 32'd0);
      step();
      RST = 1'b1;
      repeat (2) step();
      send(8'h5A, 1'b1, 1'b0);
      wait_until(busy_until + 1);

      repeat (50) step();

      for (int i = 0; i < 80; i++) begin
         int mode;
         mode = int'($urandom_range(0, 3));
         if (mode == 0) wait_until(busy_until);
         else if (mode == 1)
            wait_until(busy_until + int'($urandom_range(1, 4)));
         else if (mode == 2) begin
            if (cyc < busy_until - 2)
               send(W'($urandom), 1'($urandom), 1'($urandom));
            wait_until(busy_until);
         end
         send(W'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_until(busy_until + 3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
